flash_mem_responder: RTL and testbench

- Avalon-MM read-only slave that answers the flash_mem_* master interface driven by the flash reader.
- Serves 32-bit words from an internal memory, which a side load port preloads, with configurable wait states and read latency.
- Used as a stand-in flash for bring-up and simulation of the reader, and as a deterministic source for on-chip playback.
- Single outstanding read: there is no pipelining and no bursts.

---
 rtl/flash_mem_responder_if.sv | 20 ++
 rtl/flash_mem_responder.sv | 115 +++++++++++
 tb/tb_flash_mem_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/flash_mem_responder_if.sv
// Avalon-MM read-only bus between the flash reader (master) and the responder (slave).
interface flash_mem_responder_if;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_burstcount;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;

  modport master (
    output flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );
endinterface

// File: rtl/flash_mem_responder.sv
// Stand-in flash: single-outstanding Avalon-MM read slave over a preloadable word memory.
// Latency: WAIT_CYCLES stall cycles, then readdatavalid READ_LATENCY cycles after accept; stalls via waitrequest.
// Backpressure: waitrequest held high outside IDLE and until the wait-state count expires.
module flash_mem_responder #(
  parameter int ADDR_BITS    = 10,
  parameter int WAIT_CYCLES  = 2,
  parameter int READ_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 resetb,
  flash_mem_responder_if.slave bus,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [31:0]          load_data,
  output logic [15:0]          rd_count,
  output logic                 oob_err
);

  localparam int         DEPTH  = 2 ** ADDR_BITS;
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LAT  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  wcnt;
  logic [3:0]  lcnt;
  logic [31:0] hold_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rd_word;
  logic [31:0] masked;
  logic        addr_oob;
  logic        accept;
  logic        unused_inputs;

  // Burst length is not checked; a single-beat read is assumed.
  assign unused_inputs = &{1'b0, bus.flash_mem_burstcount};

  assign addr_oob = |bus.flash_mem_address[22:ADDR_BITS];
  assign accept   = resetb && (state == IDLE) && bus.flash_mem_read && (wcnt == WAIT_C);

  assign bus.flash_mem_waitrequest   = ~accept;
  assign bus.flash_mem_readdata      = rdata_q;
  assign bus.flash_mem_readdatavalid = (state == RESP);

  // Preload port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    rd_word = mem[bus.flash_mem_address[ADDR_BITS-1:0]];
    masked  = '0;
    for (int i = 0; i < 4; i++) begin
      masked[8*i +: 8] = bus.flash_mem_byteenable[i] ? rd_word[8*i +: 8] : 8'h00;
    end
    if (addr_oob) begin
      masked = '0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      wcnt     <= '0;
      lcnt     <= '0;
      hold_q   <= '0;
      rdata_q  <= '0;
      rd_count <= '0;
      oob_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wcnt    <= '0;
            oob_err <= oob_err | addr_oob;
            // readdata only changes when the response is presented.
            if (READ_LATENCY == 1) begin
              rdata_q <= masked;
              state   <= RESP;
            end else begin
              hold_q <= masked;
              lcnt   <= 4'd1;
              state  <= LAT;
            end
          end else if (bus.flash_mem_read) begin
            if (wcnt < WAIT_C) begin
              wcnt <= wcnt + 4'd1;
            end
          end else begin
            wcnt <= '0;
          end
        end
        LAT: begin
          lcnt <= lcnt + 4'd1;
          if (lcnt == LAT_M1) begin
            rdata_q <= hold_q;
            state   <= RESP;
          end
        end
        RESP: begin
          rd_count <= rd_count + 16'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_mem_responder.sv
// Directed bench: dut_a uses WAIT=2/LAT=3, dut_b uses WAIT=0/LAT=1 for back-to-back reads.
module tb_flash_mem_responder;

  logic        clk;
  logic        resetb;
  logic        a_load_en, b_load_en;
  logic [9:0]  a_load_addr, b_load_addr;
  logic [31:0] a_load_data, b_load_data;
  logic [15:0] a_rd_count, b_rd_count;
  logic        a_oob_err, b_oob_err;
  int          total;
  int          passed;

  flash_mem_responder_if a_bus ();
  flash_mem_responder_if b_bus ();

  flash_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2), .READ_LATENCY(3)) dut_a (
    .clk(clk), .resetb(resetb), .bus(a_bus.slave),
    .load_en(a_load_en), .load_addr(a_load_addr), .load_data(a_load_data),
    .rd_count(a_rd_count), .oob_err(a_oob_err)
  );

  flash_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0), .READ_LATENCY(1)) dut_b (
    .clk(clk), .resetb(resetb), .bus(b_bus.slave),
    .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data),
    .rd_count(b_rd_count), .oob_err(b_oob_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [9:0] addr, input logic [31:0] data);
    a_load_en = 1'b1; a_load_addr = addr; a_load_data = data;
    step();
    a_load_en = 1'b0;
  endtask

  task automatic load_b(input logic [9:0] addr, input logic [31:0] data);
    b_load_en = 1'b1; b_load_addr = addr; b_load_data = data;
    step();
    b_load_en = 1'b0;
  endtask

  // Issue one read on dut_a, optionally loading ld_val into the same address on the accept edge.
  task automatic read_a(input string tag, input logic [22:0] addr, input logic [3:0] be,
                        input logic [31:0] exp_data, input bit ld_on_acc, input logic [31:0] ld_val);
    int waits, lat;
    bit acc, got;
    a_bus.flash_mem_read       = 1'b1;
    a_bus.flash_mem_address    = addr;
    a_bus.flash_mem_byteenable = be;
    waits = 0; acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      if (a_bus.flash_mem_waitrequest === 1'b0) begin
        acc = 1'b1;
        if (ld_on_acc) begin
          a_load_en = 1'b1; a_load_addr = addr[9:0]; a_load_data = ld_val;
        end
      end else begin
        waits++;
      end
      step();
    end
    a_bus.flash_mem_read = 1'b0;
    a_load_en = 1'b0;
    check({tag, " accepted"}, 32'(acc), 32'd1);
    check({tag, " wait cycles"}, 32'(waits), 32'd2);
    lat = 0; got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (a_bus.flash_mem_readdatavalid === 1'b1) begin
        got = 1'b1;
        lat = c;
        check({tag, " readdata"}, a_bus.flash_mem_readdata, exp_data);
      end
      step();
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " rdv one cycle"}, 32'(a_bus.flash_mem_readdatavalid), 32'd0);
    check({tag, " readdata holds"}, a_bus.flash_mem_readdata, exp_data);
  endtask

  initial begin
    bit acc;
    int pulses;
    total = 0; passed = 0;
    resetb = 1'b0;
    a_load_en = 1'b0; a_load_addr = '0; a_load_data = '0;
    b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0;
    a_bus.flash_mem_read = 1'b1; a_bus.flash_mem_address = '0;
    a_bus.flash_mem_byteenable = 4'hF; a_bus.flash_mem_burstcount = 1'b1;
    b_bus.flash_mem_read = 1'b1; b_bus.flash_mem_address = '0;
    b_bus.flash_mem_byteenable = 4'hF; b_bus.flash_mem_burstcount = 1'b1;

    #3;
    check("rst a waitrequest", 32'(a_bus.flash_mem_waitrequest), 32'd1);
    check("rst b waitrequest", 32'(b_bus.flash_mem_waitrequest), 32'd1);
    check("rst a readdatavalid", 32'(a_bus.flash_mem_readdatavalid), 32'd0);
    check("rst a readdata", a_bus.flash_mem_readdata, 32'h0);
    check("rst a rd_count", 32'(a_rd_count), 32'd0);
    check("rst a oob_err", 32'(a_oob_err), 32'd0);
    a_bus.flash_mem_read = 1'b0;
    b_bus.flash_mem_read = 1'b0;
    #9 resetb = 1'b1;
    step();

    load_a(10'd5, 32'hA5A5_1234);
    load_a(10'd7, 32'h1111_1111);
    for (int i = 0; i < 4; i++) load_b(10'(i), 32'hB000_0000 + 32'(i));
    check("idle a waitrequest read=0", 32'(a_bus.flash_mem_waitrequest), 32'd1);

    read_a("full word", 23'd5, 4'b1111, 32'hA5A5_1234, 1'b0, 32'h0);
    check("rd_count 1", 32'(a_rd_count), 32'd1);
    read_a("be 0101", 23'd5, 4'b0101, 32'h00A5_0034, 1'b0, 32'h0);
    read_a("be 0000", 23'd5, 4'b0000, 32'h0000_0000, 1'b0, 32'h0);
    check("rd_count 3", 32'(a_rd_count), 32'd3);
    check("oob_err before", 32'(a_oob_err), 32'd0);
    read_a("oob addr", 23'h400, 4'b1111, 32'h0000_0000, 1'b0, 32'h0);
    check("oob_err set", 32'(a_oob_err), 32'd1);
    read_a("good after oob", 23'd5, 4'b1111, 32'hA5A5_1234, 1'b0, 32'h0);
    check("oob_err sticky", 32'(a_oob_err), 32'd1);
    read_a("same-edge load", 23'd7, 4'b1111, 32'h1111_1111, 1'b1, 32'h2222_2222);
    read_a("after load", 23'd7, 4'b1111, 32'h2222_2222, 1'b0, 32'h0);
    check("rd_count 7", 32'(a_rd_count), 32'd7);

    // dut_b: read held high across four requests, address advanced after each accept.
    b_bus.flash_mem_read = 1'b1;
    b_bus.flash_mem_address = 23'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b%0d accept", i), 32'(b_bus.flash_mem_waitrequest), 32'd0);
      check($sformatf("b%0d idle rdv", i), 32'(b_bus.flash_mem_readdatavalid), 32'd0);
      step();
      b_bus.flash_mem_address = 23'(i + 1);
      @(negedge clk);
      check($sformatf("b%0d rdv", i), 32'(b_bus.flash_mem_readdatavalid), 32'd1);
      check($sformatf("b%0d data", i), b_bus.flash_mem_readdata, 32'hB000_0000 + 32'(i));
      check($sformatf("b%0d stall in resp", i), 32'(b_bus.flash_mem_waitrequest), 32'd1);
      step();
    end
    b_bus.flash_mem_read = 1'b0;
    check("b rd_count 4", 32'(b_rd_count), 32'd4);

    // Reset while dut_a is counting latency.
    a_bus.flash_mem_read = 1'b1;
    a_bus.flash_mem_address = 23'd5;
    a_bus.flash_mem_byteenable = 4'hF;
    acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      if (a_bus.flash_mem_waitrequest === 1'b0) acc = 1'b1;
      step();
    end
    check("abort accepted", 32'(acc), 32'd1);
    #2 resetb = 1'b0;
    #1;
    check("abort waitrequest in reset", 32'(a_bus.flash_mem_waitrequest), 32'd1);
    check("abort rdv in reset", 32'(a_bus.flash_mem_readdatavalid), 32'd0);
    check("abort rd_count cleared", 32'(a_rd_count), 32'd0);
    check("abort oob_err cleared", 32'(a_oob_err), 32'd0);
    a_bus.flash_mem_read = 1'b0;
    step();
    step();
    @(negedge clk);
    resetb = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge clk);
      if (a_bus.flash_mem_readdatavalid === 1'b1) pulses++;
    end
    check("abort no rdv", 32'(pulses), 32'd0);
    step();
    read_a("after abort", 23'd5, 4'b1111, 32'hA5A5_1234, 1'b0, 32'h0);
    check("after abort rd_count", 32'(a_rd_count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
